// File: rtl/mac_pkg.sv
// mac_pkg
// Shared width constants and small helpers for the multiply-accumulate
// pipeline. Imported by mac_step2 and mac_step2_norm.
package mac_pkg;

  localparam int PROD_W       = 22;  // summed partial-product width
  localparam int SG_W         = 24;  // significand incl. hidden bit
  localparam int EXP_W        = 8;   // FP32 biased exponent width
  localparam int FP32_EXP_MSB = 30;
  localparam int FP32_EXP_LSB = 23;
  localparam int FRAC_W       = FP32_EXP_LSB;  // 23-bit fraction

  // Unsigned |a - b| in EXP_W bits
  function automatic logic [EXP_W-1:0] exp_abs_diff(
    input logic [EXP_W-1:0] a,
    input logic [EXP_W-1:0] b
  );
    logic [EXP_W-1:0] d;
    if (a >= b) begin
      d = a - b;
    end else begin
      d = b - a;
    end
    return d;
  endfunction

endpackage

// File: rtl/mac_step2_norm.sv
// mac_step2_norm
// Combinational normalization of the 22-bit product sum. The sum holds the
// product in either [2,4) (bit 21 set) or [1,2) (bit 20 set); the leading one
// becomes the hidden bit and the exponent is bumped by one in the former case.
// The exponent increment wraps modulo 256 without any saturation or flag.
//
// Ports:
//   i_prod     in  22  summed partial products
//   i_mul_ex   in  8   biased product exponent before normalization
//   o_norm_ex  out 8   normalized biased exponent
//   o_norm_sg  out 24  {1'b1, 23-bit fraction}
module mac_step2_norm
  import mac_pkg::*;
(
  input  logic [PROD_W-1:0] i_prod,
  input  logic [EXP_W-1:0]  i_mul_ex,
  output logic [EXP_W-1:0]  o_norm_ex,
  output logic [SG_W-1:0]   o_norm_sg
);

  // Select the one-position or zero-position shift based on the top sum bit
  always_comb begin
    o_norm_ex = i_mul_ex;
    o_norm_sg = {SG_W{1'b0}};
    if (i_prod[PROD_W-1]) begin
      o_norm_ex = i_mul_ex + 8'd1;
      o_norm_sg = {1'b1, i_prod[PROD_W-2:0], 2'b00};
    end else begin
      o_norm_ex = i_mul_ex;
      o_norm_sg = {1'b1, i_prod[PROD_W-3:0], 3'b000};
    end
  end

endmodule

// File: rtl/mac_step2.sv
// mac_step2
// Second MAC pipeline stage: sums the remaining partial-product rows,
// normalizes the product, optionally compares it against the addend C, and
// holds the result in a single valid/ready output register (1-cycle latency,
// full throughput, no bubble on simultaneous drain and load).
//
// Build option: MAC_STEP2_ALIGN_EN enables the ex_diff / c_larger alignment
// comparator. When undefined both outputs are tied to zero.
//
// Ports:
//   CLK, RESETn          clock, async active-low reset
//   in_valid / in_ready  upstream handshake (in_ready = !out_valid || out_ready)
//   mul_sign, mul_ex     product sign and pre-normalization exponent
//   in_C                 FP32 addend passed through
//   s_r4, p_r4_5..10     partial-product rows to be summed
//   out_valid/out_ready  downstream handshake
//   prod_sign, prod_ex, prod_sg, out_C, ex_diff, c_larger   registered results
module mac_step2
  import mac_pkg::*;
(
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mul_sign,
  input  logic [EXP_W-1:0]    mul_ex,
  input  logic [31:0]         in_C,
  input  logic [PROD_W-1:0]   s_r4,
  input  logic [PROD_W-1:0]   p_r4_5,
  input  logic [PROD_W-1:0]   p_r4_6,
  input  logic [PROD_W-1:0]   p_r4_7,
  input  logic [PROD_W-1:0]   p_r4_8,
  input  logic [PROD_W-1:0]   p_r4_9,
  input  logic [PROD_W-1:0]   p_r4_10,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                prod_sign,
  output logic [EXP_W-1:0]    prod_ex,
  output logic [SG_W-1:0]     prod_sg,
  output logic [31:0]         out_C,
  output logic [EXP_W-1:0]    ex_diff,
  output logic                c_larger
);

  logic [PROD_W-1:0] w_prod;
  logic [EXP_W-1:0]  w_norm_ex;
  logic [SG_W-1:0]   w_norm_sg;
  logic [EXP_W-1:0]  w_ex_diff;
  logic              w_c_larger;
  logic              w_load;

  logic              r_out_valid;
  logic              r_prod_sign;
  logic [EXP_W-1:0]  r_prod_ex;
  logic [SG_W-1:0]   r_prod_sg;
  logic [31:0]       r_out_C;
  logic [EXP_W-1:0]  r_ex_diff;
  logic              r_c_larger;

  // Unsigned sum, carries beyond bit 21 are intentionally dropped
  assign w_prod = s_r4 + p_r4_5 + p_r4_6 + p_r4_7 + p_r4_8 + p_r4_9 + p_r4_10;

  mac_step2_norm u_norm (
    .i_prod    (w_prod),
    .i_mul_ex  (mul_ex),
    .o_norm_ex (w_norm_ex),
    .o_norm_sg (w_norm_sg)
  );

`ifdef MAC_STEP2_ALIGN_EN
  logic [EXP_W-1:0]  w_c_ex;
  logic [FRAC_W-1:0] w_c_frac;

  assign w_c_ex   = in_C[FP32_EXP_MSB:FP32_EXP_LSB];
  assign w_c_frac = in_C[FRAC_W-1:0];

  // Magnitude compare: exponent first, fraction breaks ties
  always_comb begin
    w_ex_diff  = exp_abs_diff(w_norm_ex, w_c_ex);
    w_c_larger = 1'b0;
    if (w_c_ex > w_norm_ex) begin
      w_c_larger = 1'b1;
    end else if (w_c_ex == w_norm_ex) begin
      w_c_larger = (w_c_frac > w_norm_sg[FRAC_W-1:0]);
    end else begin
      w_c_larger = 1'b0;
    end
  end
`else
  assign w_ex_diff  = {EXP_W{1'b0}};
  assign w_c_larger = 1'b0;
`endif

  // A full register can still accept when it is being drained this cycle
  assign in_ready = !r_out_valid || out_ready;
  assign w_load   = in_valid && in_ready;

  // Output register with valid/ready hold
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_out_valid <= 1'b0;
      r_prod_sign <= 1'b0;
      r_prod_ex   <= {EXP_W{1'b0}};
      r_prod_sg   <= {SG_W{1'b0}};
      r_out_C     <= 32'd0;
      r_ex_diff   <= {EXP_W{1'b0}};
      r_c_larger  <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_prod_sign <= mul_sign;
        r_prod_ex   <= w_norm_ex;
        r_prod_sg   <= w_norm_sg;
        r_out_C     <= in_C;
        r_ex_diff   <= w_ex_diff;
        r_c_larger  <= w_c_larger;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign prod_sign = r_prod_sign;
  assign prod_ex   = r_prod_ex;
  assign prod_sg   = r_prod_sg;
  assign out_C     = r_out_C;
  assign ex_diff   = r_ex_diff;
  assign c_larger  = r_c_larger;

endmodule

// File: tb/tb_mac_step2.sv
// tb_mac_step2
// Scoreboard bench for mac_step2: expected results are computed from the
// driven operands when the handshake accepts them and compared while the
// result sits in the output register. Honours MAC_STEP2_ALIGN_EN.
module tb_mac_step2;

  logic        CLK;
  logic        RESETn;
  logic        in_valid;
  logic        in_ready;
  logic        mul_sign;
  logic [7:0]  mul_ex;
  logic [31:0] in_C;
  logic [21:0] s_r4, p_r4_5, p_r4_6, p_r4_7, p_r4_8, p_r4_9, p_r4_10;
  logic        out_valid;
  logic        out_ready;
  logic        prod_sign;
  logic [7:0]  prod_ex;
  logic [23:0] prod_sg;
  logic [31:0] out_C;
  logic [7:0]  ex_diff;
  logic        c_larger;

  typedef struct {
    logic        sign;
    logic [7:0]  ex;
    logic [23:0] sg;
    logic [31:0] c;
    logic [7:0]  diff;
    logic        cl;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  mac_step2 dut (
    .CLK(CLK), .RESETn(RESETn), .in_valid(in_valid), .in_ready(in_ready),
    .mul_sign(mul_sign), .mul_ex(mul_ex), .in_C(in_C), .s_r4(s_r4),
    .p_r4_5(p_r4_5), .p_r4_6(p_r4_6), .p_r4_7(p_r4_7), .p_r4_8(p_r4_8),
    .p_r4_9(p_r4_9), .p_r4_10(p_r4_10), .out_valid(out_valid),
    .out_ready(out_ready), .prod_sign(prod_sign), .prod_ex(prod_ex),
    .prod_sg(prod_sg), .out_C(out_C), .ex_diff(ex_diff), .c_larger(c_larger)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: sum as integers, normalize by shifting, compare magnitudes as keys
  function automatic exp_t model();
    exp_t        e;
    int unsigned sum;
    int          de;
    logic [30:0] c_key, p_key;
    sum = (s_r4 + p_r4_5 + p_r4_6 + p_r4_7 + p_r4_8 + p_r4_9 + p_r4_10) & 32'h003F_FFFF;
    e.sign = mul_sign;
    if (sum >= 32'h0020_0000) begin
      e.ex = 8'((32'(mul_ex) + 32'd1) % 32'd256);
      e.sg = 24'((sum << 2) & 32'h007F_FFFF) | 24'h80_0000;
    end else begin
      e.ex = mul_ex;
      e.sg = 24'((sum << 3) & 32'h007F_FFFF) | 24'h80_0000;
    end
    e.c = in_C;
`ifdef MAC_STEP2_ALIGN_EN
    de     = int'(e.ex) - int'(in_C[30:23]);
    if (de < 0) de = -de;
    e.diff = 8'(de);
    c_key  = in_C[30:0];
    p_key  = {e.ex, e.sg[22:0]};
    e.cl   = (c_key > p_key);
`else
    de     = 0;
    c_key  = 31'd0;
    p_key  = 31'd0;
    e.diff = 8'd0;
    e.cl   = 1'b0;
`endif
    return e;
  endfunction

  task automatic clear_ops();
    mul_sign = 1'b0; mul_ex = 8'd0; in_C = 32'd0; s_r4 = 22'd0;
    p_r4_5 = 22'd0; p_r4_6 = 22'd0; p_r4_7 = 22'd0; p_r4_8 = 22'd0;
    p_r4_9 = 22'd0; p_r4_10 = 22'd0;
  endtask

  // One clock cycle: check outputs against the scoreboard head, update it, advance
  task automatic step();
    logic exp_ready;
    #1;
    exp_ready = (sb.size() == 0) || out_ready;
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    if (sb.size() != 0) begin
      chk("prod_sign", 64'(prod_sign), 64'(sb[0].sign));
      chk("prod_ex", 64'(prod_ex), 64'(sb[0].ex));
      chk("prod_sg", 64'(prod_sg), 64'(sb[0].sg));
      chk("out_C", 64'(out_C), 64'(sb[0].c));
      chk("ex_diff", 64'(ex_diff), 64'(sb[0].diff));
      chk("c_larger", 64'(c_larger), 64'(sb[0].cl));
      if (out_ready) void'(sb.pop_front());
    end
    if (in_valid && exp_ready) sb.push_back(model());
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_sign"},  64'(prod_sign), 64'd0);
    chk({tag, "_ex"},    64'(prod_ex),   64'd0);
    chk({tag, "_sg"},    64'(prod_sg),   64'd0);
    chk({tag, "_C"},     64'(out_C),     64'd0);
    chk({tag, "_diff"},  64'(ex_diff),   64'd0);
    chk({tag, "_cl"},    64'(c_larger),  64'd0);
  endtask

  initial begin
    RESETn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    clear_ops();
    #2;
    chk_all_zero("rst");
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);

    // 1.0 x 1.0 with addend 2.0: directed expectations on top of the model
    p_r4_10 = 22'h10_0000; mul_ex = 8'd127; in_C = 32'h4000_0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0; clear_ops();
    #1;
    chk("one_valid", 64'(out_valid), 64'd1);
    chk("one_ex", 64'(prod_ex), 64'd127);
    chk("one_sg", 64'(prod_sg), 64'h80_0000);
`ifdef MAC_STEP2_ALIGN_EN
    chk("one_diff", 64'(ex_diff), 64'd1);
    chk("one_cl", 64'(c_larger), 64'd1);
`else
    chk("one_diff", 64'(ex_diff), 64'd0);
    chk("one_cl", 64'(c_larger), 64'd0);
`endif
    step();

    // 1.5 x 1.5
    p_r4_9 = 22'h0C_0000; p_r4_10 = 22'h18_0000; mul_ex = 8'd127; mul_sign = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; clear_ops();
    #1;
    chk("p15_ex", 64'(prod_ex), 64'd128);
    chk("p15_sg", 64'(prod_sg), 64'h90_0000);
    step();

    // Exponent wrap: 255 + 1 -> 0
    p_r4_10 = 22'h20_0000; mul_ex = 8'd255; in_valid = 1'b1;
    step();
    in_valid = 1'b0; clear_ops();
    #1;
    chk("wrap_ex", 64'(prod_ex), 64'd0);
    step();

    // Stall for 3 cycles with a new operand waiting, then drain+load together
    s_r4 = 22'h05_1234; p_r4_7 = 22'h0A_0000; mul_ex = 8'd100; in_C = 32'h3200_0000;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    s_r4 = 22'h12_3456; mul_ex = 8'd60; in_C = 32'hBF80_0000;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; clear_ops();
    step();
    step();

    // Reset asserted between edges while stalled
    p_r4_10 = 22'h15_5555; mul_ex = 8'd90; in_C = 32'h4100_0000;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    #2 RESETn = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    sb.delete();
    #1 RESETn = 1'b1;
    step();
    // First load after reset behaves as from idle
    p_r4_8 = 22'h0F_0F0F; mul_ex = 8'd30; in_C = 32'h0F00_0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step();

    // Random traffic with random backpressure
    for (int i = 0; i < 60; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      mul_sign  = 1'($urandom_range(0, 1));
      mul_ex    = 8'($urandom_range(0, 255));
      in_C      = $urandom;
      s_r4      = 22'($urandom);
      p_r4_5    = 22'($urandom) >> 3;
      p_r4_6    = 22'($urandom) >> 3;
      p_r4_7    = 22'($urandom) >> 3;
      p_r4_8    = 22'($urandom) >> 3;
      p_r4_9    = 22'($urandom) >> 3;
      p_r4_10   = 22'($urandom);
      if (i % 7 == 0) in_C[30:23] = mul_ex;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
